// File: rtl/minisrc_pkg.sv
// rtl/minisrc_pkg.sv - Mini SRC shared widths, ALU opcodes and bus-source encoding
package minisrc_pkg;

   localparam int WORD_W = 32;

   localparam logic [4:0] OP_LD   = 5'b00000;
   localparam logic [4:0] OP_LDI  = 5'b00001;
   localparam logic [4:0] OP_ST   = 5'b00010;
   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_SHR  = 5'b00111;
   localparam logic [4:0] OP_SHRA = 5'b01000;
   localparam logic [4:0] OP_SHL  = 5'b01001;
   localparam logic [4:0] OP_ROR  = 5'b01010;
   localparam logic [4:0] OP_ROL  = 5'b01011;
   localparam logic [4:0] OP_ADDI = 5'b01100;
   localparam logic [4:0] OP_ANDI = 5'b01101;
   localparam logic [4:0] OP_ORI  = 5'b01110;
   localparam logic [4:0] OP_MUL  = 5'b01111;
   localparam logic [4:0] OP_DIV  = 5'b10000;
   localparam logic [4:0] OP_NEG  = 5'b10001;
   localparam logic [4:0] OP_NOT  = 5'b10010;

   typedef enum logic [3:0] {
      BUS_NONE,
      BUS_GPR,
      BUS_HI,
      BUS_LO,
      BUS_ZHI,
      BUS_ZLO,
      BUS_PC,
      BUS_MDR,
      BUS_INPORT,
      BUS_C
   } bus_sel_e;

   function automatic logic [15:0] reg_onehot(input logic [3:0] idx);
      return 16'(1) << idx;
   endfunction

endpackage

// File: rtl/minisrc_alu.sv
// rtl/minisrc_alu.sv - combinational Mini SRC ALU; multiply/divide only when MINISRC_MULDIV_EN is defined
module minisrc_alu
   import minisrc_pkg::*;
(
   input  logic [4:0]        op,
   input  logic              inc_pc,
   input  logic [WORD_W-1:0] a,
   input  logic [WORD_W-1:0] b,
   output logic [WORD_W-1:0] hi,
   output logic [WORD_W-1:0] lo
);

   logic [4:0] sh;
   assign sh = b[4:0];

`ifdef MINISRC_MULDIV_EN
   logic signed [2*WORD_W-1:0] prod;
   logic signed [WORD_W-1:0]   quo;
   logic signed [WORD_W-1:0]   rem;

   assign prod = 64'($signed(a)) * 64'($signed(b));
   // Divide-by-zero is defined as 0/0 rather than left to the simulator.
   assign quo  = (b == '0) ? '0 : $signed(a) / $signed(b);
   assign rem  = (b == '0) ? '0 : $signed(a) % $signed(b);
`endif

   always_comb begin
      hi = '0;
      lo = b;
      if (inc_pc) begin
         lo = b + 1'b1;
      end else begin
         case (op)
            OP_LD, OP_LDI, OP_ST, OP_ADDI, OP_ADD: lo = a + b;
            OP_SUB:          lo = a - b;
            OP_AND, OP_ANDI: lo = a & b;
            OP_OR, OP_ORI:   lo = a | b;
            OP_SHR:          lo = a >> sh;
            OP_SHRA:         lo = $signed(a) >>> sh;
            OP_SHL:          lo = a << sh;
            OP_ROR:          lo = (a >> sh) | (a << (6'd32 - {1'b0, sh}));
            OP_ROL:          lo = (a << sh) | (a >> (6'd32 - {1'b0, sh}));
`ifdef MINISRC_MULDIV_EN
            OP_MUL: begin
               hi = prod[2*WORD_W-1:WORD_W];
               lo = prod[WORD_W-1:0];
            end
            OP_DIV: begin
               hi = rem;
               lo = quo;
            end
`else
            OP_MUL, OP_DIV:  lo = '0;
`endif
            OP_NEG:          lo = -b;
            OP_NOT:          lo = ~b;
            default:         lo = b;
         endcase
      end
   end

endmodule

// File: rtl/minisrc_datapath.sv
// rtl/minisrc_datapath.sv - Mini SRC single-bus datapath with GPRs, select/encode, CON logic and RAM (MINISRC_MULDIV_EN enables mul/div)
module minisrc_datapath #(
   parameter int MEM_DEPTH = 512,
   parameter int WORD_W    = minisrc_pkg::WORD_W
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              PC_in,
   input  logic              IR_in,
   input  logic              Y_in,
   input  logic              Z_in,
   input  logic              HI_in,
   input  logic              LO_in,
   input  logic              MAR_in,
   input  logic              MDR_in,
   input  logic              OutPort_in,
   input  logic              IncPC,
   input  logic              PC_out,
   input  logic              Zhigh_out,
   input  logic              Zlow_out,
   input  logic              HI_out,
   input  logic              LO_out,
   input  logic              MDR_out,
   input  logic              InPort_out,
   input  logic              C_out,
   input  logic              Read,
   input  logic              Write,
   input  logic              Gra,
   input  logic              Grb,
   input  logic              Grc,
   input  logic              Rin,
   input  logic              Rout,
   input  logic              BAout,
   input  logic [4:0]        alu_instruction_bits,
   input  logic [15:0]       RX_in_man,
   input  logic [15:0]       RX_out_man,
   input  logic [WORD_W-1:0] InPort_Data_In,
   output logic [15:0]       RX_in,
   output logic [15:0]       RX_out,
   output logic              CON_out,
   output logic [WORD_W-1:0] Outport_Data_Out,
   output logic [WORD_W-1:0] Bus_Data,
   output logic [WORD_W-1:0] ALUHigh_Data,
   output logic [WORD_W-1:0] ALULow_Data,
   output logic [WORD_W-1:0] Mdatain,
   output logic [WORD_W-1:0] C_sign_extended_Data,
   output logic [WORD_W-1:0] R0_Data,
   output logic [WORD_W-1:0] R1_Data,
   output logic [WORD_W-1:0] R2_Data,
   output logic [WORD_W-1:0] R3_Data,
   output logic [WORD_W-1:0] R4_Data,
   output logic [WORD_W-1:0] R5_Data,
   output logic [WORD_W-1:0] R6_Data,
   output logic [WORD_W-1:0] R7_Data,
   output logic [WORD_W-1:0] R8_Data,
   output logic [WORD_W-1:0] R9_Data,
   output logic [WORD_W-1:0] R10_Data,
   output logic [WORD_W-1:0] R11_Data,
   output logic [WORD_W-1:0] R12_Data,
   output logic [WORD_W-1:0] R13_Data,
   output logic [WORD_W-1:0] R14_Data,
   output logic [WORD_W-1:0] R15_Data,
   output logic [WORD_W-1:0] PC_Data,
   output logic [WORD_W-1:0] IR_Data,
   output logic [WORD_W-1:0] Y_Data,
   output logic [WORD_W-1:0] Zhigh_Data,
   output logic [WORD_W-1:0] Zlow_Data,
   output logic [WORD_W-1:0] HI_Data,
   output logic [WORD_W-1:0] LO_Data,
   output logic [WORD_W-1:0] MAR_Data,
   output logic [WORD_W-1:0] MDR_Data,
   output logic [WORD_W-1:0] InPort_Data
);

   import minisrc_pkg::*;

   localparam int AW = $clog2(MEM_DEPTH);

   logic [WORD_W-1:0] gpr [16];
   logic [WORD_W-1:0] outport_q;
   logic [WORD_W-1:0] mem [MEM_DEPTH] = '{0: 32'hB180_0000, default: '0};
   logic [3:0]        sel_idx;
   logic [15:0]       sel_onehot;
   bus_sel_e          bus_sel;
   logic [3:0]        bus_gpr;

   // Select-and-encode: the Gr* strobes OR together the IR register fields.
   assign sel_idx    = ({4{Gra}} & IR_Data[26:23]) | ({4{Grb}} & IR_Data[22:19]) |
                       ({4{Grc}} & IR_Data[18:15]);
   assign sel_onehot = reg_onehot(sel_idx);
   assign RX_in      = RX_in_man  | (Rin ? sel_onehot : 16'h0000);
   assign RX_out     = RX_out_man | ((Rout | BAout) ? sel_onehot : 16'h0000);

   assign C_sign_extended_Data = {{(WORD_W-19){IR_Data[18]}}, IR_Data[18:0]};

   minisrc_alu u_alu (
      .op     (alu_instruction_bits),
      .inc_pc (IncPC),
      .a      (Y_Data),
      .b      (Bus_Data),
      .hi     (ALUHigh_Data),
      .lo     (ALULow_Data)
   );

   // Sources are visited lowest priority first so the highest-priority select wins.
   always_comb begin
      bus_sel = BUS_NONE;
      bus_gpr = 4'd0;
      if (C_out)      bus_sel = BUS_C;
      if (InPort_out) bus_sel = BUS_INPORT;
      if (MDR_out)    bus_sel = BUS_MDR;
      if (PC_out)     bus_sel = BUS_PC;
      if (Zlow_out)   bus_sel = BUS_ZLO;
      if (Zhigh_out)  bus_sel = BUS_ZHI;
      if (LO_out)     bus_sel = BUS_LO;
      if (HI_out)     bus_sel = BUS_HI;
      for (int i = 15; i >= 0; i--) begin
         if (RX_out[i]) begin
            bus_sel = BUS_GPR;
            bus_gpr = 4'(i);
         end
      end
   end

   always_comb begin
      Bus_Data = '0;
      case (bus_sel)
         // BAout makes R0 read as zero for base-address computations.
         BUS_GPR:    Bus_Data = (bus_gpr == 4'd0 && BAout) ? '0 : gpr[bus_gpr];
         BUS_HI:     Bus_Data = HI_Data;
         BUS_LO:     Bus_Data = LO_Data;
         BUS_ZHI:    Bus_Data = Zhigh_Data;
         BUS_ZLO:    Bus_Data = Zlow_Data;
         BUS_PC:     Bus_Data = PC_Data;
         BUS_MDR:    Bus_Data = MDR_Data;
         BUS_INPORT: Bus_Data = InPort_Data;
         BUS_C:      Bus_Data = C_sign_extended_Data;
         default:    Bus_Data = '0;
      endcase
   end

   always_comb begin
      case (IR_Data[20:19])
         2'b00:   CON_out = (Bus_Data == '0);
         2'b01:   CON_out = (Bus_Data != '0);
         2'b10:   CON_out = ~Bus_Data[WORD_W-1];
         default: CON_out = Bus_Data[WORD_W-1];
      endcase
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         for (int i = 0; i < 16; i++) gpr[i] <= '0;
         PC_Data     <= '0;
         IR_Data     <= '0;
         Y_Data      <= '0;
         Zhigh_Data  <= '0;
         Zlow_Data   <= '0;
         HI_Data     <= '0;
         LO_Data     <= '0;
         MAR_Data    <= '0;
         MDR_Data    <= '0;
         InPort_Data <= '0;
         outport_q   <= '0;
      end else begin
         for (int i = 0; i < 16; i++) begin
            if (RX_in[i]) gpr[i] <= Bus_Data;
         end
         if (PC_in)  PC_Data  <= Bus_Data;
         if (IR_in)  IR_Data  <= Bus_Data;
         if (Y_in)   Y_Data   <= Bus_Data;
         if (HI_in)  HI_Data  <= Bus_Data;
         if (LO_in)  LO_Data  <= Bus_Data;
         if (MAR_in) MAR_Data <= Bus_Data;
         if (Z_in) begin
            Zhigh_Data <= ALUHigh_Data;
            Zlow_Data  <= ALULow_Data;
         end
         if (MDR_in)     MDR_Data  <= Read ? Mdatain : Bus_Data;
         if (OutPort_in) outport_q <= Bus_Data;
         InPort_Data <= InPort_Data_In;
      end
   end

   // RAM is not touched by clr so a program image survives reset.
   always_ff @(posedge clk) begin
      if (Write) mem[MAR_Data[AW-1:0]] <= MDR_Data;
   end

   assign Mdatain          = mem[MAR_Data[AW-1:0]];
   assign Outport_Data_Out = outport_q;

   assign R0_Data  = gpr[0];
   assign R1_Data  = gpr[1];
   assign R2_Data  = gpr[2];
   assign R3_Data  = gpr[3];
   assign R4_Data  = gpr[4];
   assign R5_Data  = gpr[5];
   assign R6_Data  = gpr[6];
   assign R7_Data  = gpr[7];
   assign R8_Data  = gpr[8];
   assign R9_Data  = gpr[9];
   assign R10_Data = gpr[10];
   assign R11_Data = gpr[11];
   assign R12_Data = gpr[12];
   assign R13_Data = gpr[13];
   assign R14_Data = gpr[14];
   assign R15_Data = gpr[15];

endmodule

// File: tb/tb_minisrc_datapath.sv
// tb/tb_minisrc_datapath.sv - directed self-checking bench for minisrc_datapath
module tb_minisrc_datapath;

   logic        clk = 1'b0;
   logic        clr;
   logic        PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in, OutPort_in;
   logic        IncPC;
   logic        PC_out, Zhigh_out, Zlow_out, HI_out, LO_out, MDR_out, InPort_out, C_out;
   logic        Read, Write;
   logic        Gra, Grb, Grc, Rin, Rout, BAout;
   logic [4:0]  alu_instruction_bits;
   logic [15:0] RX_in_man, RX_out_man;
   logic [31:0] InPort_Data_In;
   logic [15:0] RX_in, RX_out;
   logic        CON_out;
   logic [31:0] Outport_Data_Out, Bus_Data, ALUHigh_Data, ALULow_Data, Mdatain, C_sign_extended_Data;
   logic [31:0] R0_Data, R1_Data, R2_Data, R3_Data, R4_Data, R5_Data, R6_Data, R7_Data;
   logic [31:0] R8_Data, R9_Data, R10_Data, R11_Data, R12_Data, R13_Data, R14_Data, R15_Data;
   logic [31:0] PC_Data, IR_Data, Y_Data, Zhigh_Data, Zlow_Data, HI_Data, LO_Data;
   logic [31:0] MAR_Data, MDR_Data, InPort_Data;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   minisrc_datapath dut (
      .clk(clk), .clr(clr),
      .PC_in(PC_in), .IR_in(IR_in), .Y_in(Y_in), .Z_in(Z_in), .HI_in(HI_in), .LO_in(LO_in),
      .MAR_in(MAR_in), .MDR_in(MDR_in), .OutPort_in(OutPort_in), .IncPC(IncPC),
      .PC_out(PC_out), .Zhigh_out(Zhigh_out), .Zlow_out(Zlow_out), .HI_out(HI_out),
      .LO_out(LO_out), .MDR_out(MDR_out), .InPort_out(InPort_out), .C_out(C_out),
      .Read(Read), .Write(Write), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
      .BAout(BAout), .alu_instruction_bits(alu_instruction_bits),
      .RX_in_man(RX_in_man), .RX_out_man(RX_out_man), .InPort_Data_In(InPort_Data_In),
      .RX_in(RX_in), .RX_out(RX_out), .CON_out(CON_out), .Outport_Data_Out(Outport_Data_Out),
      .Bus_Data(Bus_Data), .ALUHigh_Data(ALUHigh_Data), .ALULow_Data(ALULow_Data),
      .Mdatain(Mdatain), .C_sign_extended_Data(C_sign_extended_Data),
      .R0_Data(R0_Data), .R1_Data(R1_Data), .R2_Data(R2_Data), .R3_Data(R3_Data),
      .R4_Data(R4_Data), .R5_Data(R5_Data), .R6_Data(R6_Data), .R7_Data(R7_Data),
      .R8_Data(R8_Data), .R9_Data(R9_Data), .R10_Data(R10_Data), .R11_Data(R11_Data),
      .R12_Data(R12_Data), .R13_Data(R13_Data), .R14_Data(R14_Data), .R15_Data(R15_Data),
      .PC_Data(PC_Data), .IR_Data(IR_Data), .Y_Data(Y_Data), .Zhigh_Data(Zhigh_Data),
      .Zlow_Data(Zlow_Data), .HI_Data(HI_Data), .LO_Data(LO_Data), .MAR_Data(MAR_Data),
      .MDR_Data(MDR_Data), .InPort_Data(InPort_Data)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      {PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in, OutPort_in} = '0;
      {IncPC, PC_out, Zhigh_out, Zlow_out, HI_out, LO_out, MDR_out, InPort_out, C_out} = '0;
      {Read, Write, Gra, Grb, Grc, Rin, Rout, BAout} = '0;
      alu_instruction_bits = 5'b00000;
      RX_in_man  = 16'h0000;
      RX_out_man = 16'h0000;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      clr = 1'b0;
      idle();
      InPort_Data_In = 32'h0;
      repeat (2) step();
      clr = 1'b1;

      // Load R1, then reset asynchronously
      InPort_Data_In = 32'h55;
      step();
      InPort_out = 1'b1; RX_in_man = 16'h0002;
      step();
      chk("r1_load", R1_Data, 32'h55);
      idle();
      InPort_Data_In = 32'h0;
      clr = 1'b0;
      #1;
      chk("rst_r1", R1_Data, 32'h0);
      chk("rst_inport", InPort_Data, 32'h0);
      chk("rst_pc", PC_Data, 32'h0);
      chk("rst_bus", Bus_Data, 32'h0);
      clr = 1'b1;
      #1;

      // Fetch
      PC_out = 1'b1; MAR_in = 1'b1; IncPC = 1'b1; Z_in = 1'b1;
      step(); idle();
      chk("fetch_mar", MAR_Data, 32'h0);
      chk("fetch_zlow", Zlow_Data, 32'h1);
      Zlow_out = 1'b1; PC_in = 1'b1; Read = 1'b1; MDR_in = 1'b1;
      step(); idle();
      chk("fetch_pc", PC_Data, 32'h1);
      chk("fetch_mdr", MDR_Data, 32'hB180_0000);
      MDR_out = 1'b1; IR_in = 1'b1;
      step(); idle();
      chk("fetch_ir", IR_Data, 32'hB180_0000);

      // in R3 (Ra = 3)
      InPort_Data_In = 32'h1020_FCAE;
      Gra = 1'b1; Rin = 1'b1; InPort_out = 1'b1;
      #1;
      chk("in_rxin", 32'(RX_in), 32'h0008);
      step(); step(); idle();
      chk("in_r3", R3_Data, 32'h1020_FCAE);

      // ALU with Y=5, Bus=7
      InPort_Data_In = 32'd5;
      step();
      InPort_out = 1'b1; Y_in = 1'b1;
      step(); idle();
      chk("y_load", Y_Data, 32'd5);
      InPort_Data_In = 32'd7;
      step();
      InPort_out = 1'b1; alu_instruction_bits = 5'b00011; Z_in = 1'b1;
      #1;
      chk("alu_bus", Bus_Data, 32'd7);
      step();
      chk("alu_add", Zlow_Data, 32'd12);
      alu_instruction_bits = 5'b00100;
      step();
      chk("alu_sub", Zlow_Data, 32'hFFFF_FFFE);
      Z_in = 1'b0;
      alu_instruction_bits = 5'b01010; #1;
      chk("alu_ror", ALULow_Data, 32'h0A00_0000);
      alu_instruction_bits = 5'b01011; #1;
      chk("alu_rol", ALULow_Data, 32'h0000_0280);
      alu_instruction_bits = 5'b00101; #1;
      chk("alu_and", ALULow_Data, 32'd5);
      alu_instruction_bits = 5'b10001; #1;
      chk("alu_neg", ALULow_Data, 32'hFFFF_FFF9);
      alu_instruction_bits = 5'b10010; #1;
      chk("alu_not", ALULow_Data, 32'hFFFF_FFF8);
      alu_instruction_bits = 5'b11111; #1;
      chk("alu_default", ALULow_Data, 32'd7);
      alu_instruction_bits = 5'b00100; IncPC = 1'b1; #1;
      chk("alu_incpc", ALULow_Data, 32'd8);
      IncPC = 1'b0;
`ifdef MINISRC_MULDIV_EN
      alu_instruction_bits = 5'b01111; #1;
      chk("mul_lo", ALULow_Data, 32'd35);
      chk("mul_hi", ALUHigh_Data, 32'd0);
      alu_instruction_bits = 5'b10000; #1;
      chk("div_q", ALULow_Data, 32'd0);
      chk("div_r", ALUHigh_Data, 32'd5);
      idle();
      InPort_Data_In = 32'h0001_0000;
      step();
      InPort_out = 1'b1; Y_in = 1'b1;
      step();
      Y_in = 1'b0; alu_instruction_bits = 5'b01111; Z_in = 1'b1;
      step(); idle();
      chk("mul_zhigh", Zhigh_Data, 32'h1);
      chk("mul_zlow", Zlow_Data, 32'h0);
`else
      alu_instruction_bits = 5'b01111; #1;
      chk("mul_off_lo", ALULow_Data, 32'd0);
      chk("mul_off_hi", ALUHigh_Data, 32'd0);
      alu_instruction_bits = 5'b10000; #1;
      chk("div_off_lo", ALULow_Data, 32'd0);
      chk("div_off_hi", ALUHigh_Data, 32'd0);
`endif
      idle();

      // CON with IR[20:19]=00
      #1;
      chk("con_eq_zero", 32'(CON_out), 32'd1);
      InPort_Data_In = 32'd5;
      step();
      InPort_out = 1'b1; #1;
      chk("con_eq_five", 32'(CON_out), 32'd0);
      idle();

      // IR with [20:19]=11 and negative 19-bit constant
      InPort_Data_In = 32'h001C_0000;
      step();
      InPort_out = 1'b1; IR_in = 1'b1;
      step(); idle();
      chk("ir_con", IR_Data, 32'h001C_0000);
      chk("c_sext", C_sign_extended_Data, 32'hFFFC_0000);
      C_out = 1'b1; #1;
      chk("c_bus", Bus_Data, 32'hFFFC_0000);
      C_out = 1'b0;
      InPort_Data_In = 32'h8000_0000;
      step();
      InPort_out = 1'b1; #1;
      chk("con_neg", 32'(CON_out), 32'd1);
      InPort_Data_In = 32'd5;
      step();
      chk("con_pos", 32'(CON_out), 32'd0);
      OutPort_in = 1'b1;
      step(); idle();
      chk("outport", Outport_Data_Out, 32'd5);

      // Memory write/read at address 5
      InPort_out = 1'b1; MAR_in = 1'b1;
      step(); idle();
      chk("mem_mar", MAR_Data, 32'd5);
      chk("mem_before", Mdatain, 32'd0);
      InPort_Data_In = 32'hDEAD_BEEF;
      step();
      InPort_out = 1'b1; MDR_in = 1'b1;
      step(); idle();
      chk("mem_mdr", MDR_Data, 32'hDEAD_BEEF);
      Write = 1'b1;
      step(); idle();
      chk("mem_after", Mdatain, 32'hDEAD_BEEF);

      // BAout forces R0 to read as zero
      IR_in = 1'b1;
      step(); idle();
      chk("ir_zero", IR_Data, 32'h0);
      InPort_Data_In = 32'd9;
      step();
      InPort_out = 1'b1; RX_in_man = 16'h0001;
      step(); idle();
      chk("r0_load", R0_Data, 32'd9);
      Gra = 1'b1; BAout = 1'b1; #1;
      chk("ba_rxout", 32'(RX_out), 32'h0001);
      chk("ba_bus", Bus_Data, 32'h0);
      BAout = 1'b0; Rout = 1'b1; #1;
      chk("rout_bus", Bus_Data, 32'd9);
      idle();
      InPort_Data_In = 32'h77;
      step();
      RX_out_man = 16'h0001; InPort_out = 1'b1; #1;
      chk("bus_priority", Bus_Data, 32'd9);
      idle();
      chk("r3_kept", R3_Data, 32'h1020_FCAE);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
